chip_seq_ctrl: RTL and testbench
================================

Name: chip_seq_ctrl

Overview:
Sequencer for the ISFET chip readout path. It holds the chip in reset, releases it, waits for calibration, then counts mux_update strobes into per-pixel sample enables with pixel index and frame markers for the packing/FIFO datapath. It sits between the host start/stop controls and the ADC sample packer, and owns chip_nrst and the frame structure.

Parameters:
PIXELS_PER_FRAME, 16400, samples per frame (656 words x 25 samples of 10 bits)
RST_CYCLES, 64, sys_clk cycles chip_nrst is held low after start
CALI_TIMEOUT, 1000000, max sys_clk cycles to wait for cali_done
NUM_FRAMES, 0, frames per run; 0 = continuous until stop_req
IDX_W, $clog2(PIXELS_PER_FRAME), pixel_idx width

Ports:
sys_clk  in  1  system clock
sys_nrst  in  1  asynchronous active-low reset
sys_start  in  1  level; rising edge starts a run
stop_req  in  1  level; finish current frame then stop
err_clr  in  1  one-cycle pulse; leave ERROR
cali_done  in  1  chip calibration done, already synchronised to sys_clk
mux_update  in  1  chip mux strobe, already synchronised to sys_clk
fifo_full  in  1  downstream packer/FIFO cannot accept a sample
sys_rdy  out  1  high in IDLE only
chip_nrst  out  1  active-low chip reset
sample_valid  out  1  one-cycle capture enable for ADC_DATA
pixel_idx  out  IDX_W  index of current sample, valid with sample_valid
end_of_frame  out  1  one-cycle pulse with the last sample of a frame
frame_cnt  out  16  frames completed this run, wraps at 65535->0
overflow  out  1  sticky; a sample was dropped due to fifo_full
err_code  out  2  0 none, 1 calibration timeout, 2 cali_done lost during run
readout_LED  out  1  high in RUN

Behaviour:
- Reset (async, sys_nrst low): state IDLE, sys_rdy=1, chip_nrst=0, sample_valid=0, end_of_frame=0, pixel_idx=0, frame_cnt=0, overflow=0, err_code=0, readout_LED=0. All outputs are registered.
- Edge detect: sys_start and mux_update use a 1-cycle registered previous value. Rising edge = current 1 and previous 0. A mux_update held high counts once.
- IDLE: on sys_start rising edge, go to CHIP_RST. Clear pixel_idx, frame_cnt, overflow and err_code. sys_rdy goes 0 the next cycle.
- CHIP_RST: chip_nrst=0 for exactly RST_CYCLES cycles. chip_nrst goes 1 in the same cycle the state enters CALI_WAIT.
- CALI_WAIT: a timeout counter runs from 0.
  - cali_done=1: go to RUN.
  - Counter reaches CALI_TIMEOUT-1 without cali_done: go to ERROR with err_code=1.
  - If cali_done and timeout occur in the same cycle, cali_done wins.
- RUN, on each mux_update rising edge, registered with 1-cycle latency:
  - If fifo_full=0: sample_valid=1 for one cycle, with pixel_idx set to the current count.
  - If fifo_full=1: sample_valid stays 0 and overflow is set (sticky). pixel_idx still advances so the frame keeps its alignment.
  - When the count is PIXELS_PER_FRAME-1: end_of_frame=1 in the same cycle (even if the sample was dropped), the count wraps to 0, and frame_cnt increments.
- Run termination, evaluated at the end_of_frame cycle:
  - Stop if stop_req=1, or if NUM_FRAMES!=0 and frame_cnt+1==NUM_FRAMES.
  - Next state is IDLE and chip_nrst returns to 0.
  - stop_req asserted mid-frame is latched; the frame is always completed.
- Calibration loss: cali_done=0 in RUN goes to ERROR with err_code=2. Any partial frame is abandoned with no end_of_frame. If cali_done falls in the same cycle as a mux_update edge, ERROR wins and no sample is issued.
- ERROR: chip_nrst=0, sys_rdy=0, readout_LED=0, err_code held. An err_clr pulse goes to IDLE and clears err_code. sys_start is ignored while in ERROR.
- sys_start is ignored outside IDLE. A level held high from before reset exit does not start a run, because the previous value resets to 1.
- The pixel counter never exceeds PIXELS_PER_FRAME-1. frame_cnt wraps at 16 bits.

Test Plan:
1. PIXELS_PER_FRAME=8, RST_CYCLES=4, NUM_FRAMES=2. Pulse start; cali_done rises 10 cycles later; 16 mux_update pulses spaced 3 cycles apart.
   -> chip_nrst low exactly 4 cycles; 16 sample_valid with pixel_idx 0..7, 0..7; end_of_frame at idx 7 twice; frame_cnt=2; return to IDLE with sys_rdy=1.
2. CALI_TIMEOUT=100 and cali_done never rises.
   -> ERROR after 100 cycles in CALI_WAIT with err_code=1 and chip_nrst=0. err_clr returns to IDLE with err_code=0.
3. NUM_FRAMES=0; stop_req pulsed at pixel_idx 3 of frame 0.
   -> frame completes through idx 7 with end_of_frame; IDLE next; frame_cnt=1.
4. fifo_full high during pixels 2-3.
   -> no sample_valid for idx 2,3; pixel_idx continues 4..7; overflow=1 and stays set until the next start.
5. cali_done drops at pixel_idx 5, coincident with a mux_update edge.
   -> no sample for that edge; err_code=2; no end_of_frame; chip_nrst=0.
6. sys_nrst asserted mid-RUN, and again with mux_update held high for 5 cycles.
   -> all outputs return to reset values immediately; a held mux_update yields exactly one sample.

Source files
------------

// File: rtl/chip_seq_ctrl.sv
// ISFET chip readout sequencer: chip reset, calibration wait, then mux_update
// strobes become per-pixel sample enables with pixel index and frame markers.
module chip_seq_ctrl #(
    parameter int PIXELS_PER_FRAME = 16400,
    parameter int RST_CYCLES       = 64,
    parameter int CALI_TIMEOUT     = 1000000,
    parameter int NUM_FRAMES       = 0,
    parameter int IDX_W            = $clog2(PIXELS_PER_FRAME)
) (
    input  logic             sys_clk,
    input  logic             sys_nrst,
    input  logic             sys_start,
    input  logic             stop_req,
    input  logic             err_clr,
    input  logic             cali_done,
    input  logic             mux_update,
    input  logic             fifo_full,
    output logic             sys_rdy,
    output logic             chip_nrst,
    output logic             sample_valid,
    output logic [IDX_W-1:0] pixel_idx,
    output logic             end_of_frame,
    output logic [15:0]      frame_cnt,
    output logic             overflow,
    output logic [1:0]       err_code,
    output logic             readout_LED
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int CAL_W = (CALI_TIMEOUT > 1) ? $clog2(CALI_TIMEOUT) : 1;
    localparam logic [IDX_W-1:0] LAST_PIX = IDX_W'(PIXELS_PER_FRAME - 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CALI_TIMEOUT - 1);
    localparam logic [31:0]      NF       = 32'(NUM_FRAMES);

    typedef enum logic [2:0] {S_IDLE, S_CHIP_RST, S_CALI_WAIT, S_RUN, S_ERROR} state_t;

    state_t           state;
    logic             start_prev, mux_prev, stop_lat;
    logic [IDX_W-1:0] pix_cnt;
    logic [RST_W-1:0] rst_cnt;
    logic [CAL_W-1:0] cali_cnt;
    logic             start_rise, mux_rise, last_frame;

    assign start_rise = sys_start & ~start_prev;
    assign mux_rise   = mux_update & ~mux_prev;
    assign last_frame = (NF != 32'd0) && (({16'd0, frame_cnt} + 32'd1) == NF);

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state        <= S_IDLE;
            // previous values reset high so a level held through reset is not an edge
            start_prev   <= 1'b1;
            mux_prev     <= 1'b1;
            stop_lat     <= 1'b0;
            pix_cnt      <= '0;
            rst_cnt      <= '0;
            cali_cnt     <= '0;
            sys_rdy      <= 1'b1;
            chip_nrst    <= 1'b0;
            sample_valid <= 1'b0;
            pixel_idx    <= '0;
            end_of_frame <= 1'b0;
            frame_cnt    <= '0;
            overflow     <= 1'b0;
            err_code     <= 2'd0;
            readout_LED  <= 1'b0;
        end else begin
            start_prev   <= sys_start;
            mux_prev     <= mux_update;
            sample_valid <= 1'b0;
            end_of_frame <= 1'b0;
            case (state)
                S_IDLE: if (start_rise) begin
                    state     <= S_CHIP_RST;
                    sys_rdy   <= 1'b0;
                    chip_nrst <= 1'b0;
                    rst_cnt   <= '0;
                    pix_cnt   <= '0;
                    pixel_idx <= '0;
                    frame_cnt <= '0;
                    overflow  <= 1'b0;
                    err_code  <= 2'd0;
                    stop_lat  <= 1'b0;
                end
                S_CHIP_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state     <= S_CALI_WAIT;
                        chip_nrst <= 1'b1;
                        cali_cnt  <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                S_CALI_WAIT: begin
                    if (cali_done) begin
                        state       <= S_RUN;
                        readout_LED <= 1'b1;
                        pix_cnt     <= '0;
                    end else if (cali_cnt == CAL_LAST) begin
                        state     <= S_ERROR;
                        chip_nrst <= 1'b0;
                        err_code  <= 2'd1;
                    end else begin
                        cali_cnt <= cali_cnt + CAL_W'(1);
                    end
                end
                S_RUN: begin
                    // calibration loss beats any coincident strobe; partial frame is dropped
                    if (!cali_done) begin
                        state       <= S_ERROR;
                        chip_nrst   <= 1'b0;
                        readout_LED <= 1'b0;
                        err_code    <= 2'd2;
                    end else begin
                        if (stop_req) stop_lat <= 1'b1;
                        if (mux_rise) begin
                            sample_valid <= ~fifo_full;
                            if (fifo_full) overflow <= 1'b1;
                            pixel_idx <= pix_cnt;
                            if (pix_cnt == LAST_PIX) begin
                                end_of_frame <= 1'b1;
                                pix_cnt      <= '0;
                                frame_cnt    <= frame_cnt + 16'd1;
                                if (stop_req || stop_lat || last_frame) begin
                                    state       <= S_IDLE;
                                    chip_nrst   <= 1'b0;
                                    readout_LED <= 1'b0;
                                    sys_rdy     <= 1'b1;
                                end
                            end else begin
                                pix_cnt <= pix_cnt + IDX_W'(1);
                            end
                        end
                    end
                end
                S_ERROR: if (err_clr) begin
                    state    <= S_IDLE;
                    err_code <= 2'd0;
                    sys_rdy  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip_seq_ctrl.sv
// Directed bench for chip_seq_ctrl: instance 0 stops after two frames,
// instance 1 runs continuously; both share the same stimulus.
module tb_chip_seq_ctrl;

    localparam int PPF = 8;
    localparam int RSTC = 4;
    localparam int CTO = 100;
    localparam int IW = 3;

    logic sys_clk = 1'b0;
    logic sys_nrst = 1'b0, sys_start = 1'b0, stop_req = 1'b0, err_clr = 1'b0;
    logic cali_done = 1'b0, mux_update = 1'b0, fifo_full = 1'b0;

    logic          rdy_o[2], cnrst_o[2], sv_o[2], eof_o[2], ovf_o[2], led_o[2];
    logic [IW-1:0] idx_o[2];
    logic [15:0]   fc_o[2];
    logic [1:0]    ec_o[2];

    always #5 sys_clk = ~sys_clk;

    chip_seq_ctrl #(.PIXELS_PER_FRAME(PPF), .RST_CYCLES(RSTC), .CALI_TIMEOUT(CTO), .NUM_FRAMES(2)) u_nf2 (
        .sys_clk(sys_clk), .sys_nrst(sys_nrst), .sys_start(sys_start), .stop_req(stop_req),
        .err_clr(err_clr), .cali_done(cali_done), .mux_update(mux_update), .fifo_full(fifo_full),
        .sys_rdy(rdy_o[0]), .chip_nrst(cnrst_o[0]), .sample_valid(sv_o[0]), .pixel_idx(idx_o[0]),
        .end_of_frame(eof_o[0]), .frame_cnt(fc_o[0]), .overflow(ovf_o[0]), .err_code(ec_o[0]),
        .readout_LED(led_o[0]));

    chip_seq_ctrl #(.PIXELS_PER_FRAME(PPF), .RST_CYCLES(RSTC), .CALI_TIMEOUT(CTO), .NUM_FRAMES(0)) u_cont (
        .sys_clk(sys_clk), .sys_nrst(sys_nrst), .sys_start(sys_start), .stop_req(stop_req),
        .err_clr(err_clr), .cali_done(cali_done), .mux_update(mux_update), .fifo_full(fifo_full),
        .sys_rdy(rdy_o[1]), .chip_nrst(cnrst_o[1]), .sample_valid(sv_o[1]), .pixel_idx(idx_o[1]),
        .end_of_frame(eof_o[1]), .frame_cnt(fc_o[1]), .overflow(ovf_o[1]), .err_code(ec_o[1]),
        .readout_LED(led_o[1]));

    typedef struct {
        logic ff;
        logic stop_after;
        logic exp_valid;
        int   exp_idx;
        logic exp_eof;
        int   exp_frames;
        logic exp_ovf;
    } vec_t;

    vec_t t1[16];
    vec_t t3[8];
    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic vec_t mk(logic ff, logic st, logic v, int idx, logic eof, int fr, logic ov);
        vec_t r;
        r = '{ff, st, v, idx, eof, fr, ov};
        return r;
    endfunction

    task automatic check_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, " sys_rdy"}, rdy_o[k], 1);
            check({tag, " chip_nrst"}, cnrst_o[k], 0);
            check({tag, " sample_valid"}, sv_o[k], 0);
            check({tag, " end_of_frame"}, eof_o[k], 0);
            check({tag, " pixel_idx"}, idx_o[k], 0);
            check({tag, " frame_cnt"}, fc_o[k], 0);
            check({tag, " overflow"}, ovf_o[k], 0);
            check({tag, " err_code"}, ec_o[k], 0);
            check({tag, " readout_LED"}, led_o[k], 0);
        end
    endtask

    // one mux_update pulse, then two idle cycles (3-cycle spacing)
    task automatic apply_vec(input vec_t v);
        mux_update = 1'b1;
        fifo_full = v.ff;
        tick();
        for (int k = 0; k < 2; k++) begin
            check("vec sample_valid", sv_o[k], v.exp_valid);
            check("vec pixel_idx", idx_o[k], v.exp_idx);
            check("vec end_of_frame", eof_o[k], v.exp_eof);
            check("vec frame_cnt", fc_o[k], v.exp_frames);
            check("vec overflow", ovf_o[k], v.exp_ovf);
        end
        mux_update = 1'b0;
        fifo_full = 1'b0;
        if (v.stop_after) stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        for (int k = 0; k < 2; k++) check("vec valid one cycle", sv_o[k], 0);
        tick();
    endtask

    task automatic run_up(input int cali_delay);
        int n;
        cali_done = 1'b0;
        sys_start = 1'b1;
        tick();
        sys_start = 1'b0;
        for (int k = 0; k < 2; k++) check("start sys_rdy low", rdy_o[k], 0);
        n = 0;
        while (cnrst_o[0] == 1'b0 && n < 50) begin
            n++;
            tick();
        end
        check("chip_nrst low cycles", n, RSTC);
        check("chip_nrst released inst1", cnrst_o[1], 1);
        repeat (cali_delay) tick();
        cali_done = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            check("run readout_LED", led_o[k], 1);
            check("run err_code", ec_o[k], 0);
            check("run frame_cnt", fc_o[k], 0);
            check("run overflow cleared", ovf_o[k], 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int c0, c1;
        for (int i = 0; i < 16; i++)
            t1[i] = mk(1'b0, 1'b0, 1'b1, i % 8, (i % 8 == 7), i / 8 + ((i % 8 == 7) ? 1 : 0), 1'b0);
        for (int i = 0; i < 8; i++)
            t3[i] = mk((i == 2 || i == 3), (i == 3), !(i == 2 || i == 3), i, (i == 7),
                       (i == 7) ? 1 : 0, (i >= 2));

        repeat (3) tick();
        check_reset("reset");
        sys_nrst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) check("idle sys_rdy", rdy_o[k], 1);

        // two full frames; instance 0 stops, instance 1 keeps running
        run_up(8);
        for (int i = 0; i < 16; i++) apply_vec(t1[i]);
        check("nf2 done sys_rdy", rdy_o[0], 1);
        check("nf2 done chip_nrst", cnrst_o[0], 0);
        check("nf2 done frame_cnt", fc_o[0], 2);
        check("nf2 done LED", led_o[0], 0);
        check("cont still running", rdy_o[1], 0);
        check("cont LED", led_o[1], 1);
        check("cont frame_cnt", fc_o[1], 2);
        for (int i = 0; i < 3; i++) begin
            mux_update = 1'b1;
            tick();
            check("cont third frame valid", sv_o[1], 1);
            check("cont third frame idx", idx_o[1], i);
            check("idle ignores mux", sv_o[0], 0);
            mux_update = 1'b0;
            tick();
            tick();
        end

        // async reset mid-run, with start held through reset exit
        #2;
        sys_nrst = 1'b0;
        sys_start = 1'b1;
        #1;
        check_reset("mid-run reset");
        tick();
        tick();
        sys_nrst = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            check("held start no run sys_rdy", rdy_o[k], 1);
            check("held start no run chip_nrst", cnrst_o[k], 0);
        end
        sys_start = 1'b0;
        tick();

        // stop mid-frame plus fifo_full drops on pixels 2-3
        run_up(2);
        for (int i = 0; i < 8; i++) apply_vec(t3[i]);
        for (int k = 0; k < 2; k++) begin
            check("stop idle sys_rdy", rdy_o[k], 1);
            check("stop frame_cnt", fc_o[k], 1);
            check("stop overflow sticky", ovf_o[k], 1);
            check("stop chip_nrst", cnrst_o[k], 0);
            check("stop LED", led_o[k], 0);
        end

        // calibration lost coincident with a strobe at pixel 5
        run_up(2);
        for (int i = 0; i < 5; i++) apply_vec(mk(1'b0, 1'b0, 1'b1, i, 1'b0, 0, 1'b0));
        cali_done = 1'b0;
        mux_update = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            check("cali lost no sample", sv_o[k], 0);
            check("cali lost no eof", eof_o[k], 0);
            check("cali lost err_code", ec_o[k], 2);
            check("cali lost chip_nrst", cnrst_o[k], 0);
            check("cali lost LED", led_o[k], 0);
            check("cali lost sys_rdy", rdy_o[k], 0);
        end
        mux_update = 1'b0;
        sys_start = 1'b1;
        tick();
        sys_start = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            check("start ignored in error code", ec_o[k], 2);
            check("start ignored in error rdy", rdy_o[k], 0);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("err_clr sys_rdy", rdy_o[k], 1);
            check("err_clr err_code", ec_o[k], 0);
        end

        // calibration timeout
        cali_done = 1'b0;
        sys_start = 1'b1;
        tick();
        sys_start = 1'b0;
        n = 0;
        while (cnrst_o[0] == 1'b0 && n < 50) begin
            n++;
            tick();
        end
        check("timeout chip_nrst low cycles", n, RSTC);
        n = 0;
        while (cnrst_o[0] == 1'b1 && n < 300) begin
            n++;
            tick();
        end
        check("cali wait cycles", n, CTO);
        for (int k = 0; k < 2; k++) begin
            check("timeout err_code", ec_o[k], 1);
            check("timeout chip_nrst", cnrst_o[k], 0);
            check("timeout sys_rdy", rdy_o[k], 0);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("timeout clr sys_rdy", rdy_o[k], 1);
            check("timeout clr err_code", ec_o[k], 0);
        end

        // mux_update held high counts once, then reset while it is still high
        run_up(0);
        mux_update = 1'b1;
        c0 = 0;
        c1 = 0;
        repeat (5) begin
            tick();
            c0 += int'(sv_o[0]);
            c1 += int'(sv_o[1]);
        end
        check("held mux samples inst0", c0, 1);
        check("held mux samples inst1", c1, 1);
        check("held mux idx", idx_o[0], 0);
        #2;
        sys_nrst = 1'b0;
        #1;
        check_reset("held mux reset");
        mux_update = 1'b0;
        tick();
        sys_nrst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
